// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] PC_CTRL_SEQ = 8'h00;
  localparam logic [ADDR_W-1:0] PC_CTRL_JMP = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_HALT,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    OP_SEQ,
    OP_HALT,
    OP_RET,
    OP_CALL,
    OP_BRANCH
  } op_t;

  // Resolves simultaneous decode requests: halt > ret > call > taken branch > sequential.
  function automatic op_t decode_op(input logic halt_req,
                                    input logic ret_req,
                                    input logic call_req,
                                    input logic branch_req,
                                    input logic branch_cond);
    if (halt_req)                      return OP_HALT;
    else if (ret_req)                  return OP_RET;
    else if (call_req)                 return OP_CALL;
    else if (branch_req && branch_cond) return OP_BRANCH;
    else                               return OP_SEQ;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. With PC_SEQ_RAS_WRAP_EN defined, a push
// into a full stack overwrites the oldest entry instead of being refused.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

`ifdef PC_SEQ_RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || WRAP);
  assign pop_ok  = pop && !empty;
  assign top     = mem[wr_ptr - PW'(1)];

  // When full, wr_ptr already points at the oldest entry, so a wrapping push
  // overwrites it naturally; only the occupancy stays pinned at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push_ok) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop_ok) begin
      wr_ptr <= wr_ptr - PW'(1);
      count  <= count - CW'(1);
    end
  end

  // NOTE: storage is deliberately left out of reset; count gates every read,
  // so stale contents are never observed and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC control for the 8-bit PC datapath (next = pc + 1 + (pc_control & jump_offset)).
// Optional macro PC_SEQ_RAS_WRAP_EN: RAS overflow wraps instead of faulting.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          pc,
  input  logic                       instr_valid,
  input  logic                       stall,
  input  logic                       branch_req,
  input  logic                       branch_cond,
  input  logic                       call_req,
  input  logic                       ret_req,
  input  logic                       halt_req,
  input  logic                       resume,
  input  logic [ADDR_W-1:0]          branch_offset,
  output logic                       pc_step,
  output logic [ADDR_W-1:0]          pc_control,
  output logic [ADDR_W-1:0]          jump_offset,
  output logic                       flush,
  output logic                       halted,
  output logic                       fault,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

`ifdef PC_SEQ_RAS_WRAP_EN
  localparam bit OVF_FAULT = 1'b0;
`else
  localparam bit OVF_FAULT = 1'b1;
`endif

  state_t            state;
  state_t            next_state;
  logic              fault_q;
  logic              set_fault;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full;
  logic              ras_empty;

  pc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc + ADDR_W'(1)),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // NOTE: state and sticky flags use non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      fault_q <= 1'b0;
    end else begin
      state <= next_state;
      if (set_fault) fault_q <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    pc_step     = 1'b0;
    pc_control  = PC_CTRL_SEQ;
    jump_offset = '0;
    flush       = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    set_fault   = 1'b0;

    case (state)
      ST_IDLE: next_state = ST_RUN;

      ST_RUN: begin
        if (instr_valid && !stall) begin
          case (decode_op(halt_req, ret_req, call_req, branch_req, branch_cond))
            OP_HALT: next_state = ST_HALT;
            OP_RET: begin
              if (ras_empty) begin
                set_fault  = 1'b1;
                next_state = ST_FAULT;
              end else begin
                pc_step     = 1'b1;
                pc_control  = PC_CTRL_JMP;
                jump_offset = ras_top - pc - ADDR_W'(1);
                ras_pop     = 1'b1;
                next_state  = ST_FLUSH;
              end
            end
            OP_CALL: begin
              if (OVF_FAULT && ras_full) begin
                set_fault  = 1'b1;
                next_state = ST_FAULT;
              end else begin
                pc_step     = 1'b1;
                pc_control  = PC_CTRL_JMP;
                jump_offset = branch_offset;
                ras_push    = 1'b1;
                next_state  = ST_FLUSH;
              end
            end
            OP_BRANCH: begin
              pc_step     = 1'b1;
              pc_control  = PC_CTRL_JMP;
              jump_offset = branch_offset;
              next_state  = ST_FLUSH;
            end
            default: pc_step = 1'b1;
          endcase
        end
      end

      // The instruction fetched behind a redirect is discarded; the PC keeps
      // stepping sequentially from the new target.
      ST_FLUSH: begin
        flush = 1'b1;
        if (!stall) begin
          pc_step    = 1'b1;
          next_state = ST_RUN;
        end
      end

      ST_HALT: if (resume) next_state = ST_RUN;

      ST_FAULT: next_state = ST_FAULT;

      default: next_state = ST_IDLE;
    endcase

    // Nothing may advance the PC or touch the RAS while reset is held.
    if (rst) begin
      pc_step     = 1'b0;
      pc_control  = PC_CTRL_SEQ;
      jump_offset = '0;
      flush       = 1'b0;
      ras_push    = 1'b0;
      ras_pop     = 1'b0;
      set_fault   = 1'b0;
    end
  end

  assign halted = (state == ST_HALT);
  assign fault  = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; follows PC_SEQ_RAS_WRAP_EN if defined.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pc;
  logic       instr_valid, stall, branch_req, branch_cond;
  logic       call_req, ret_req, halt_req, resume;
  logic [7:0] branch_offset;
  logic       pc_step;
  logic [7:0] pc_control, jump_offset;
  logic       flush, halted, fault;
  logic [2:0] ras_count;

  typedef struct packed {
    logic       step;
    logic [7:0] ctl;
    logic [7:0] jo;
    logic       fl;
    logic       hl;
    logic       ft;
    logic [2:0] rc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer #(.RAS_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .branch_req    (branch_req),
    .branch_cond   (branch_cond),
    .call_req      (call_req),
    .ret_req       (ret_req),
    .halt_req      (halt_req),
    .resume        (resume),
    .branch_offset (branch_offset),
    .pc_step       (pc_step),
    .pc_control    (pc_control),
    .jump_offset   (jump_offset),
    .flush         (flush),
    .halted        (halted),
    .fault         (fault),
    .ras_count     (ras_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [7:0] p, input logic v, input logic st,
                     input logic br, input logic bc, input logic ca,
                     input logic re, input logic ha, input logic rs,
                     input logic [7:0] off);
    pc = p; instr_valid = v; stall = st; branch_req = br; branch_cond = bc;
    call_req = ca; ret_req = re; halt_req = ha; resume = rs; branch_offset = off;
  endtask

  task automatic plain(input logic [7:0] p);
    drv(p, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic expect_out(input logic s, input logic [7:0] c, input logic [7:0] j,
                            input logic f, input logic h, input logic t,
                            input logic [2:0] r);
    sb.push_back(exp_t'{s, c, j, f, h, t, r});
  endtask

  // Compare on the falling edge, then advance past the next rising edge.
  task automatic tick(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc_step"},     {7'd0, pc_step}, {7'd0, e.step});
      chk({tag, ".pc_control"},  pc_control,      e.ctl);
      chk({tag, ".jump_offset"}, jump_offset,     e.jo);
      chk({tag, ".flush"},       {7'd0, flush},   {7'd0, e.fl});
      chk({tag, ".halted"},      {7'd0, halted},  {7'd0, e.hl});
      chk({tag, ".fault"},       {7'd0, fault},   {7'd0, e.ft});
      chk({tag, ".ras_count"},   {5'd0, ras_count}, {5'd0, e.rc});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("reset");

    // Plain instructions after the single IDLE cycle.
    rst = 1'b0;
    plain(8'h00); expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("idle");
    plain(8'h00); expect_out(1, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("seq0");
    plain(8'h01); expect_out(1, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("seq1");
    plain(8'h02); expect_out(1, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("seq2");

    // Taken branch, flush ignores a call request, then untaken branch.
    drv(8'h05, 1, 0, 1, 1, 0, 0, 0, 0, 8'h03);
    expect_out(1, 8'hFF, 8'h03, 0, 0, 0, 3'd0); tick("br_taken");
    drv(8'h09, 1, 0, 0, 0, 1, 0, 0, 0, 8'h40);
    expect_out(1, 8'h00, 8'h00, 1, 0, 0, 3'd0); tick("br_flush");
    drv(8'h0A, 1, 0, 1, 0, 0, 0, 0, 0, 8'h03);
    expect_out(1, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("br_untaken");

    // Call, stalled flush, stalled/invalid ret, ret.
    drv(8'h10, 1, 0, 0, 0, 1, 0, 0, 0, 8'h20);
    expect_out(1, 8'hFF, 8'h20, 0, 0, 0, 3'd0); tick("call");
    drv(8'h30, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
    expect_out(0, 8'h00, 8'h00, 1, 0, 0, 3'd1); tick("flush_stall");
    plain(8'h30);
    expect_out(1, 8'h00, 8'h00, 1, 0, 0, 3'd1); tick("call_flush");
    drv(8'h40, 1, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd1); tick("run_stall");
    drv(8'h40, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd1); tick("run_invalid");
    drv(8'h40, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    expect_out(1, 8'hFF, 8'hD0, 0, 0, 0, 3'd1); tick("ret");
    plain(8'h11);
    expect_out(1, 8'h00, 8'h00, 1, 0, 0, 3'd0); tick("ret_flush");

    // Halt wins over call; resume.
    drv(8'h12, 1, 0, 0, 0, 1, 0, 1, 0, 8'h08);
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("halt_req");
    drv(8'h12, 1, 0, 0, 0, 1, 0, 0, 0, 8'h08);
    expect_out(0, 8'h00, 8'h00, 0, 1, 0, 3'd0); tick("halted");
    drv(8'h12, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    expect_out(0, 8'h00, 8'h00, 0, 1, 0, 3'd0); tick("resume");
    plain(8'h13);
    expect_out(1, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("after_resume");

    // Fill the RAS.
    for (int i = 0; i < DEPTH; i++) begin
      drv(8'h20 + 8'(i * 16), 1, 0, 0, 0, 1, 0, 0, 0, 8'h05);
      expect_out(1, 8'hFF, 8'h05, 0, 0, 0, 3'(i)); tick("nest_call");
      plain(8'h25 + 8'(i * 16));
      expect_out(1, 8'h00, 8'h00, 1, 0, 0, 3'(i + 1)); tick("nest_flush");
    end

    drv(8'h60, 1, 0, 0, 0, 1, 0, 0, 0, 8'h05);
`ifdef PC_SEQ_RAS_WRAP_EN
    expect_out(1, 8'hFF, 8'h05, 0, 0, 0, 3'd4); tick("wrap_call");
    plain(8'h65);
    expect_out(1, 8'h00, 8'h00, 1, 0, 0, 3'd4); tick("wrap_flush");
    // Entry 8'h21 was overwritten: pops return 61, 51, 41, 31.
    for (int k = 0; k < DEPTH; k++) begin
      drv(8'h70, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
      expect_out(1, 8'hFF, 8'hF0 - 8'(k * 16), 0, 0, 0, (k == 0) ? 3'd4 : 3'(4 - k));
      tick("wrap_ret");
      plain(8'h71);
      expect_out(1, 8'h00, 8'h00, 1, 0, 0, 3'(3 - k)); tick("wrap_ret_flush");
    end
    drv(8'h70, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("wrap_underflow");
    plain(8'h70);
    expect_out(0, 8'h00, 8'h00, 0, 0, 1, 3'd0); tick("wrap_fault");
    rst = 1'b1;
    expect_out(0, 8'h00, 8'h00, 0, 0, 1, 3'd0); tick("fault_rst");
`else
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd4); tick("overflow");
    plain(8'h60);
    expect_out(0, 8'h00, 8'h00, 0, 0, 1, 3'd4); tick("fault_hold0");
    drv(8'h60, 1, 0, 1, 1, 0, 0, 0, 1, 8'h02);
    expect_out(0, 8'h00, 8'h00, 0, 0, 1, 3'd4); tick("fault_hold1");
    rst = 1'b1;
    expect_out(0, 8'h00, 8'h00, 0, 0, 1, 3'd4); tick("fault_rst");
`endif

    // Underflow from a clean start.
    rst = 1'b0;
    plain(8'h00); expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("idle2");
    drv(8'h01, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("underflow");
    plain(8'h01);
    expect_out(0, 8'h00, 8'h00, 0, 0, 1, 3'd0); tick("underflow_fault");
    rst = 1'b1;
    expect_out(0, 8'h00, 8'h00, 0, 0, 1, 3'd0); tick("fault_rst2");

    // Reset while in FLUSH discards the pushed return address.
    rst = 1'b0;
    plain(8'h00); expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("idle3");
    drv(8'h10, 1, 0, 0, 0, 1, 0, 0, 0, 8'h20);
    expect_out(1, 8'hFF, 8'h20, 0, 0, 0, 3'd0); tick("call2");
    rst = 1'b1;
    plain(8'h30);
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd1); tick("rst_in_flush");
    rst = 1'b0;
    plain(8'h00);
    expect_out(0, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("idle_after_rst");
    plain(8'h00);
    expect_out(1, 8'h00, 8'h00, 0, 0, 0, 3'd0); tick("run_after_rst");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
